pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed 32-bit fetch/decode pipeline register.
- An elastic pipeline stage: a DEPTH-entry in-order buffer carrying instruction word plus PC between two pipeline stages.
- Adds valid/ready handshake, synchronous flush (bubble insertion), hold (legacy write-disable) and a bubble statistics counter.
- Instantiated between IF and ID first; usable between any two stages.

Parameters:
DATA_W, 32, instruction/payload width
PC_W, 32, PC width carried alongside payload
DEPTH, 2, buffer entries; legal 1..4 (1 = plain stage register, 2 = skid buffer)
NOP_VALUE, 32'h0000_0000, out_inst value whenever the buffer is empty (DATA_W bits)
STAT_W, 16, bubble counter width
OCC_W, $clog2(DEPTH+1), occupancy width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
in_valid  in  1  upstream offers in_inst/in_pc
in_ready  out  1  stage accepts this cycle
in_inst  in  DATA_W  incoming instruction
in_pc  in  PC_W  incoming PC
out_valid  out  1  head entry presented downstream
out_ready  in  1  downstream consumes head this cycle
out_inst  out  DATA_W  head instruction, NOP_VALUE when empty
out_pc  out  PC_W  head PC, 0 when empty
hold  in  1  freeze stage (hazard-unit stall)
flush  in  1  discard all entries (branch/exception)
occupancy  out  OCC_W  entries currently held
bubble_cnt  out  STAT_W  cycles downstream was ready but no valid entry

Behaviour:
- Reset (rst=0, async): count=0, read/write pointers=0, bubble_cnt=0. Outputs: out_valid=0, out_inst=NOP_VALUE, out_pc=0, occupancy=0, in_ready=0 while rst=0. Storage contents don't care.
- push = in_valid & in_ready; pop = out_valid & out_ready; both act on the rising edge.
- out_valid = (count!=0) & ~hold.
- Data path: out_inst/out_pc are a mux of registered storage at the read pointer. No combinational path from in_* to out_*.
- Latency: an entry pushed at edge N is visible on out_* after edge N. Strict FIFO order.
- in_ready:
  - DEPTH>=2: (count<DEPTH) & ~hold & rst, derived only from registered state, so there is no out_ready→in_ready path.
  - DEPTH=1: ((count==0) | out_ready) & ~hold & rst. Pass-through ready is permitted.
- Simultaneous push and pop: count unchanged and both pointers advance. Reachable when full only for DEPTH=1.
- Pointers wrap modulo DEPTH. Overflow is impossible by construction; in_valid while in_ready=0 is ignored (the upstream must hold).
- hold=1: no push, no pop; storage and count frozen; out_* still show head data but out_valid=0.
- flush=1: at the next edge count=0 and pointers=0. Any push or pop in the same cycle is discarded. flush has priority over hold and push. out_valid=0 and out_inst=NOP_VALUE from the next cycle.
- bubble_cnt: increments when out_ready=1 & out_valid=0 & hold=0 & flush=0. Saturates at 2^STAT_W-1. Cleared only by reset.
- occupancy = count, registered.
- Reset asserted mid-transfer: all entries lost immediately; no partial state survives.

Test Plan:
- Reset then stream, DEPTH=2: push 0x8C010004/pc 0x0, 0x00221820/pc 0x4 with out_ready=1 → out_valid rises one cycle after each push, order preserved, occupancy never exceeds 1, bubble_cnt increments only on idle ready cycles.
- Backpressure, DEPTH=2: out_ready=0, push A,B,C → A,B accepted, in_ready=0 after 2nd push, C held upstream; raise out_ready → A,B,C delivered in order, occupancy 2→…→0.
- Hold: buffer holds A, assert hold 3 cycles with out_ready=1 → out_valid=0, out_inst=A, in_ready=0, occupancy unchanged, bubble_cnt unchanged; release → A popped next edge.
- Flush priority: occupancy=2, assert flush with in_valid=1 (D) and hold=1 → next cycle occupancy=0, out_inst=0x00000000, out_pc=0, D never appears.
- DEPTH=1 pass-through: full with A, out_ready=1 and in_valid=1 (B) in same cycle → A popped and B pushed on one edge, occupancy stays 1, in_ready=1 that cycle.
- Async reset mid-stream and saturation (STAT_W=4): drive rst=0 between edges → out_valid=0 and occupancy=0 without a clock edge. Then 20 idle-ready cycles → bubble_cnt stops at 15.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Elastic in-order pipeline stage: DEPTH-entry buffer carrying instruction + PC
// with valid/ready handshake, hold, flush and a saturating bubble counter.
module pipe_stage_buf #(
  parameter int                 DATA_W    = 32,
  parameter int                 PC_W      = 32,
  parameter int                 DEPTH     = 2,
  parameter logic [DATA_W-1:0]  NOP_VALUE = '0,
  parameter int                 STAT_W    = 16,
  localparam int                OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  input  logic              hold,
  input  logic              flush,
  output logic [OCC_W-1:0]  occupancy,
  output logic [STAT_W-1:0] bubble_cnt
);

  localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0]  OCC_FULL = OCC_W'(DEPTH);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [DATA_W-1:0] inst_mem_q [DEPTH];
  logic [PC_W-1:0]   pc_mem_q   [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]  count_q, count_d;
  logic [STAT_W-1:0] bubble_q, bubble_d;

  logic push;
  logic pop;
  logic empty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count_q == '0);
  assign out_valid = ~empty & ~hold;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Deeper buffers decouple ready from downstream; a single register must
  // pass out_ready through to sustain full throughput.
  generate
    if (DEPTH == 1) begin : g_ready_pass
      assign in_ready = (empty | out_ready) & ~hold & rst;
    end else begin : g_ready_reg
      assign in_ready = (count_q < OCC_FULL) & ~hold & rst;
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && !flush && (wr_ptr_q == PTR_W'(gi))) begin
          inst_mem_q[gi] <= in_inst;
          pc_mem_q[gi]   <= in_pc;
        end
      end
    end
  endgenerate

  assign out_inst   = empty ? NOP_VALUE : inst_mem_q[rd_ptr_q];
  assign out_pc     = empty ? '0 : pc_mem_q[rd_ptr_q];
  assign occupancy  = count_q;
  assign bubble_cnt = bubble_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    bubble_d = bubble_q;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    // A bubble is a cycle the consumer was willing but nothing was offered.
    if (out_ready && !out_valid && !hold && !flush && (bubble_q != STAT_MAX)) begin
      bubble_d = bubble_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      bubble_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      bubble_q <= bubble_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench: a DEPTH=2 instance for stream/backpressure/hold/flush/reset,
// a DEPTH=1, STAT_W=4 instance for pass-through ready and counter saturation.
module tb_pipe_stage_buf;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // DEPTH=2 instance signals
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_hold, a_flush;
  logic [31:0] a_in_inst, a_in_pc, a_out_inst, a_out_pc;
  logic [1:0]  a_occ;
  logic [15:0] a_bubble;

  // DEPTH=1 instance signals
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_hold, b_flush;
  logic [31:0] b_in_inst, b_in_pc, b_out_inst, b_out_pc;
  logic [0:0]  b_occ;
  logic [3:0]  b_bubble;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_buf #(
    .DATA_W(32), .PC_W(32), .DEPTH(2), .NOP_VALUE(32'h0000_0000), .STAT_W(16)
  ) u_d2 (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inst(a_in_inst), .in_pc(a_in_pc),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_inst(a_out_inst), .out_pc(a_out_pc),
    .hold(a_hold), .flush(a_flush), .occupancy(a_occ), .bubble_cnt(a_bubble)
  );

  pipe_stage_buf #(
    .DATA_W(32), .PC_W(32), .DEPTH(1), .NOP_VALUE(32'h0000_0000), .STAT_W(4)
  ) u_d1 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inst(b_in_inst), .in_pc(b_in_pc),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_inst(b_out_inst), .out_pc(b_out_pc),
    .hold(b_hold), .flush(b_flush), .occupancy(b_occ), .bubble_cnt(b_bubble)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_in_valid = 0; a_in_inst = 0; a_in_pc = 0; a_out_ready = 0; a_hold = 0; a_flush = 0;
    b_in_valid = 0; b_in_inst = 0; b_in_pc = 0; b_out_ready = 0; b_hold = 0; b_flush = 0;

    // Reset state
    #1 rst = 1'b0;
    #1;
    check("rst_a_out_valid", a_out_valid, 0);
    check("rst_a_out_inst",  a_out_inst, 32'h0);
    check("rst_a_out_pc",    a_out_pc, 32'h0);
    check("rst_a_occ",       a_occ, 0);
    check("rst_a_in_ready",  a_in_ready, 0);
    check("rst_a_bubble",    a_bubble, 0);
    check("rst_b_in_ready",  b_in_ready, 0);
    check("rst_b_occ",       b_occ, 0);
    #16 rst = 1'b1;

    // Stream with out_ready=1
    a_in_valid = 1; a_in_inst = 32'h8C01_0004; a_in_pc = 32'h0; a_out_ready = 1;
    #1;
    check("s0_in_ready", a_in_ready, 1);
    check("s0_out_valid", a_out_valid, 0);
    tick;
    check("s1_out_valid", a_out_valid, 1);
    check("s1_out_inst", a_out_inst, 32'h8C01_0004);
    check("s1_out_pc", a_out_pc, 32'h0);
    check("s1_occ", a_occ, 1);
    check("s1_bubble", a_bubble, 1);
    a_in_inst = 32'h0022_1820; a_in_pc = 32'h4;
    #1;
    check("s1_in_ready", a_in_ready, 1);
    tick;
    check("s2_out_inst", a_out_inst, 32'h0022_1820);
    check("s2_out_pc", a_out_pc, 32'h4);
    check("s2_occ", a_occ, 1);
    check("s2_bubble", a_bubble, 1);
    a_in_valid = 0;
    tick;
    check("s3_out_valid", a_out_valid, 0);
    check("s3_occ", a_occ, 0);
    check("s3_out_inst", a_out_inst, 32'h0);
    check("s3_bubble", a_bubble, 1);
    a_out_ready = 0;

    // Backpressure: A,B accepted, C waits
    a_in_valid = 1; a_in_inst = 32'h1111_1111; a_in_pc = 32'h100;
    #1 check("bp_a_in_ready", a_in_ready, 1);
    tick;
    check("bp_occ1", a_occ, 1);
    a_in_inst = 32'h2222_2222; a_in_pc = 32'h104;
    #1 check("bp_b_in_ready", a_in_ready, 1);
    tick;
    check("bp_occ2", a_occ, 2);
    a_in_inst = 32'h3333_3333; a_in_pc = 32'h108;
    #1 check("bp_full_in_ready", a_in_ready, 0);
    tick;
    check("bp_still2", a_occ, 2);
    check("bp_head_a", a_out_inst, 32'h1111_1111);
    a_out_ready = 1;
    #1 check("bp_no_ready_path", a_in_ready, 0);
    tick;
    check("bp_occ_after_pop", a_occ, 1);
    check("bp_head_b", a_out_inst, 32'h2222_2222);
    check("bp_head_b_pc", a_out_pc, 32'h104);
    #1 check("bp_c_in_ready", a_in_ready, 1);
    tick;
    check("bp_occ_pp", a_occ, 1);
    check("bp_head_c", a_out_inst, 32'h3333_3333);
    check("bp_head_c_pc", a_out_pc, 32'h108);
    a_in_valid = 0;
    tick;
    check("bp_empty", a_occ, 0);
    check("bp_bubble", a_bubble, 1);
    a_out_ready = 0;

    // Hold
    a_in_valid = 1; a_in_inst = 32'hAAAA_0001; a_in_pc = 32'h200;
    tick;
    check("h_occ", a_occ, 1);
    a_hold = 1; a_out_ready = 1; a_in_inst = 32'hDEAD_0000; a_in_pc = 32'h204;
    #1;
    check("h_out_valid", a_out_valid, 0);
    check("h_out_inst", a_out_inst, 32'hAAAA_0001);
    check("h_in_ready", a_in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("h_occ_frozen", a_occ, 1);
      check("h_bubble_frozen", a_bubble, 1);
      check("h_inst_frozen", a_out_inst, 32'hAAAA_0001);
    end
    a_hold = 0; a_in_valid = 0;
    #1 check("h_release_valid", a_out_valid, 1);
    tick;
    check("h_popped", a_occ, 0);
    check("h_bubble_after", a_bubble, 1);
    a_out_ready = 0;

    // Flush beats hold and push
    a_in_valid = 1; a_in_inst = 32'hF100_0001; a_in_pc = 32'h280;
    tick;
    a_in_inst = 32'hF100_0002; a_in_pc = 32'h284;
    tick;
    check("f_occ2", a_occ, 2);
    a_flush = 1; a_hold = 1; a_out_ready = 1; a_in_inst = 32'hD0D0_D0D0; a_in_pc = 32'h300;
    tick;
    a_flush = 0; a_hold = 0; a_in_valid = 0; a_out_ready = 0;
    check("f_occ0", a_occ, 0);
    check("f_out_inst", a_out_inst, 32'h0);
    check("f_out_pc", a_out_pc, 32'h0);
    check("f_out_valid", a_out_valid, 0);
    check("f_bubble", a_bubble, 1);
    tick;
    check("f_stay_empty", a_occ, 0);
    a_in_valid = 1; a_in_inst = 32'hC0DE_0001; a_in_pc = 32'h400;
    tick;
    a_in_valid = 0;
    check("f_refill_inst", a_out_inst, 32'hC0DE_0001);
    check("f_refill_pc", a_out_pc, 32'h400);

    // Async reset between edges
    #3 rst = 1'b0;
    #1;
    check("ar_out_valid", a_out_valid, 0);
    check("ar_occ", a_occ, 0);
    check("ar_out_inst", a_out_inst, 32'h0);
    check("ar_in_ready", a_in_ready, 0);
    check("ar_bubble", a_bubble, 0);
    #2 rst = 1'b1;
    tick;

    // DEPTH=1 pass-through ready
    b_in_valid = 1; b_in_inst = 32'h0A0A_0A0A; b_in_pc = 32'h40;
    #1 check("d1_in_ready_empty", b_in_ready, 1);
    tick;
    check("d1_occ", b_occ, 1);
    check("d1_head_a", b_out_inst, 32'h0A0A_0A0A);
    b_in_valid = 0;
    #1 check("d1_full_no_ready", b_in_ready, 0);
    b_out_ready = 1; b_in_valid = 1; b_in_inst = 32'h0B0B_0B0B; b_in_pc = 32'h44;
    #1 check("d1_pass_ready", b_in_ready, 1);
    tick;
    check("d1_occ_same", b_occ, 1);
    check("d1_head_b", b_out_inst, 32'h0B0B_0B0B);
    check("d1_head_b_pc", b_out_pc, 32'h44);
    check("d1_bubble0", b_bubble, 0);
    b_in_valid = 0;
    tick;
    check("d1_empty", b_occ, 0);
    check("d1_empty_valid", b_out_valid, 0);
    check("d1_bubble_still0", b_bubble, 0);

    // Saturation: 20 idle-ready cycles on a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      tick;
      if (i == 9) check("sat_mid", b_bubble, 10);
    end
    check("sat_top", b_bubble, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
